router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx_if.sv | 29 ++
 rtl/router_pkt_tx.sv | 178 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet transmitter.
// The master side drives requests, payload and router status.
// The slave side is the transmitter itself.
interface router_pkt_tx_if;
    logic       req_valid;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_ready;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       busy;
    logic       err;
    logic       done;
    logic       err_flag;
    logic       reject;

    modport master (
        output req_valid, req_addr, req_len, pl_data, pl_valid, busy, err,
        input  req_ready, pl_ready, data_out, pkt_valid, done, err_flag, reject
    );

    modport slave (
        input  req_valid, req_addr, req_len, pl_data, pl_valid, busy, err,
        output req_ready, pl_ready, data_out, pkt_valid, done, err_flag, reject
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then streams the header, the
// payload and an XOR parity byte to a router.
// A byte on data_out is consumed at any rising edge where busy is low.
// After the parity byte, the router error line is watched for three cycles
// and the result is reported together with a done pulse.
module router_pkt_tx #(
    parameter int DEPTH = 64
) (
    input logic            clock,
    input logic            resetn,
    router_pkt_tx_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, FILL, HEADER, PAYLOAD, PARITY, CHK_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic [5:0] count_q, count_d;
    logic [5:0] index_q, index_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] data_out_q, data_out_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       done_q, done_d;
    logic       err_flag_q, err_flag_d;
    logic       reject_q, reject_d;
    logic [1:0] cw_cnt_q, cw_cnt_d;

    logic [7:0]    buffer [DEPTH];
    logic          buf_we;
    logic [5:0]    rd_idx;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [7:0]    rd_data;
    logic          accept;

    // The byte on data_out moves on only when the router is not stalling.
    assign accept  = !bus.busy;
    // Look one byte ahead so data_out can be loaded on the accepting edge.
    assign rd_idx  = (state_q == HEADER) ? 6'd0 : (index_q + 6'd1);
    assign rd_addr = AW'(rd_idx);
    assign wr_addr = AW'(count_q);
    assign rd_data = buffer[rd_addr];

    assign bus.req_ready = (state_q == IDLE);
    assign bus.pl_ready  = (state_q == FILL);
    assign bus.data_out  = data_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.done      = done_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.reject    = reject_q;

    // Next-state and next-output logic for the transmit sequence.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        count_d     = count_q;
        index_d     = index_q;
        parity_d    = parity_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        err_flag_d  = err_flag_q;
        cw_cnt_d    = cw_cnt_q;
        done_d      = 1'b0;
        reject_d    = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    err_flag_d = 1'b0;
                    if (bus.req_addr == 2'b11 || bus.req_len == 6'd0) begin
                        reject_d = 1'b1;
                    end else begin
                        addr_d   = bus.req_addr;
                        len_d    = bus.req_len;
                        parity_d = {bus.req_len, bus.req_addr};
                        count_d  = 6'd0;
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ bus.pl_data;
                    count_d  = count_q + 6'd1;
                    if (count_q == len_q - 6'd1) begin
                        state_d     = HEADER;
                        data_out_d  = {len_q, addr_q};
                        pkt_valid_d = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (accept) begin
                    state_d    = PAYLOAD;
                    index_d    = 6'd0;
                    data_out_d = rd_data;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (index_q == len_q - 6'd1) begin
                        state_d     = PARITY;
                        data_out_d  = parity_q;
                        pkt_valid_d = 1'b0;
                    end else begin
                        index_d    = index_q + 6'd1;
                        data_out_d = rd_data;
                    end
                end
            end
            PARITY: begin
                if (accept) begin
                    state_d    = CHK_WAIT;
                    data_out_d = 8'h00;
                    cw_cnt_d   = 2'd0;
                end
            end
            CHK_WAIT: begin
                err_flag_d = err_flag_q | bus.err;
                cw_cnt_d   = cw_cnt_q + 2'd1;
                if (cw_cnt_q == 2'd2) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any packet in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            count_q     <= 6'd0;
            index_q     <= 6'd0;
            parity_q    <= 8'h00;
            data_out_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            reject_q    <= 1'b0;
            cw_cnt_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            count_q     <= count_d;
            index_q     <= index_d;
            parity_q    <= parity_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            err_flag_q  <= err_flag_d;
            reject_q    <= reject_d;
            cw_cnt_q    <= cw_cnt_d;
        end
    end

    // Payload buffer write; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buffer[wr_addr] <= bus.pl_data;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: a cycle table for short packets,
// rejects and the error report, then sequences for stalls, a full-length
// packet and reset in the middle of a payload.
module tb_router_pkt_tx;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] payload [64];

    router_pkt_tx_if bus ();

    router_pkt_tx #(.DEPTH(64)) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [1:0]  ra;
        logic [5:0]  rl;
        logic        plv;
        logic [7:0]  pld;
        logic        bz;
        logic        er;
        logic [13:0] exp;  // {req_ready, pl_ready, data_out, pkt_valid, done, err_flag, reject}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int rv, input int ra, input int rl, input int plv,
                               input int pld, input int bz, input int er,
                               input int rr, input int plr, input int d, input int pk,
                               input int dn, input int ef, input int rj);
        vec_t t;
        t.rv  = rv[0];
        t.ra  = ra[1:0];
        t.rl  = rl[5:0];
        t.plv = plv[0];
        t.pld = pld[7:0];
        t.bz  = bz[0];
        t.er  = er[0];
        t.exp = {rr[0], plr[0], d[7:0], pk[0], dn[0], ef[0], rj[0]};
        return t;
    endfunction

    function automatic logic [13:0] outs();
        return {bus.req_ready, bus.pl_ready, bus.data_out, bus.pkt_valid,
                bus.done, bus.err_flag, bus.reject};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_addr  = 2'd0;
        bus.req_len   = 6'd0;
        bus.pl_data   = 8'h00;
        bus.pl_valid  = 1'b0;
        bus.busy      = 1'b0;
        bus.err       = 1'b0;
    endtask

    task automatic send_req(input logic [1:0] a, input logic [5:0] l);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        cyc();
        bus.req_valid = 1'b0;
    endtask

    task automatic fill(input int len, input bit toggle);
        int k = 0;
        int g = 0;
        while (k < len && g < 400) begin
            bus.pl_valid = (!toggle || (g % 2 == 0));
            bus.pl_data  = payload[k];
            cyc();
            if (bus.pl_valid) k++;
            g++;
        end
        bus.pl_valid = 1'b0;
        check("fill_count", 32'(k), 32'(len));
        check("pl_ready_after_fill", 32'(bus.pl_ready), 32'd0);
    endtask

    task automatic drain(input int len, input logic [7:0] hdr, input int stall_k, input int stall_n);
        logic [7:0] par;
        logic [7:0] exp_d;
        logic       exp_pv;
        int         got;
        par = hdr;
        for (int j = 0; j < len; j++) par = par ^ payload[j];
        for (int k = 0; k < len + 2; k++) begin
            if (k == 0) begin
                exp_d = hdr; exp_pv = 1'b1;
            end else if (k <= len) begin
                exp_d = payload[k-1]; exp_pv = 1'b1;
            end else begin
                exp_d = par; exp_pv = 1'b0;
            end
            if (k == stall_k) begin
                bus.busy = 1'b1;
                for (int s = 0; s < stall_n; s++) begin
                    #1;
                    check($sformatf("stall_b%0d_c%0d", k, s),
                          32'({bus.pkt_valid, bus.data_out}), 32'({exp_pv, exp_d}));
                    cyc();
                end
                bus.busy = 1'b0;
            end
            #1;
            check($sformatf("byte%0d", k), 32'({bus.pkt_valid, bus.data_out}), 32'({exp_pv, exp_d}));
            cyc();
        end
        got = -1;
        for (int i = 0; i < 8 && got < 0; i++) begin
            #1;
            if (bus.done) got = i;
            else cyc();
        end
        check("done_latency", 32'(got), 32'd3);
        check("err_flag_at_done", 32'(bus.err_flag), 32'd0);
        cyc();
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        // addr=1 len=3 payload 11,22,33; stray req/pl ignored outside IDLE/FILL
        vecs.push_back(v(1,1,3, 0,'h00,0,0, 1,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 1,'h11,0,0, 0,1,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 1,'h22,0,0, 0,1,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 1,'h33,0,0, 0,1,'h00,0,0,0,0));
        vecs.push_back(v(1,0,5, 0,'h00,0,0, 0,0,'h0D,1,0,0,0));
        vecs.push_back(v(0,0,0, 1,'hFF,0,0, 0,0,'h11,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h22,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h33,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h0D,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 1,0,'h00,0,1,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 1,0,'h00,0,0,0,0));
        // invalid requests: addr=3, then len=0
        vecs.push_back(v(1,3,5, 0,'h00,0,0, 1,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 1,0,'h00,0,0,0,1));
        vecs.push_back(v(1,1,0, 0,'h00,0,0, 1,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 1,0,'h00,0,0,0,1));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 1,0,'h00,0,0,0,0));
        // addr=0 len=1 payload AA, header stalled once, err in CHK_WAIT
        vecs.push_back(v(1,0,1, 0,'h00,0,0, 1,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 1,'hAA,0,0, 0,1,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,1,0, 0,0,'h04,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h04,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'hAA,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'hAE,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,1, 0,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,1,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,1,0));
        // done with err_flag; next request (addr=0 len=1 payload 55) clears it
        vecs.push_back(v(1,0,1, 0,'h00,0,0, 1,0,'h00,0,1,1,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,1,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 1,'h55,0,0, 0,1,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h04,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h55,1,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h51,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 0,0,'h00,0,0,0,0));
        vecs.push_back(v(0,0,0, 0,'h00,0,0, 1,0,'h00,0,1,0,0));

        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}));
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.req_valid = vecs[i].rv;
            bus.req_addr  = vecs[i].ra;
            bus.req_len   = vecs[i].rl;
            bus.pl_valid  = vecs[i].plv;
            bus.pl_data   = vecs[i].pld;
            bus.busy      = vecs[i].bz;
            bus.err       = vecs[i].er;
            #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            cyc();
        end
        idle_inputs();
        cyc();

        // payload byte 22 stalled for 4 cycles
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        send_req(2'd1, 6'd3);
        fill(3, 1'b0);
        drain(3, 8'h0D, 2, 4);

        // full-length packet with pl_valid toggling and a short stall
        for (int j = 0; j < 64; j++) payload[j] = 8'(j * 7 + 3);
        send_req(2'd2, 6'd63);
        fill(63, 1'b1);
        drain(63, 8'hFE, 10, 2);

        // reset while payload index 10 is on data_out
        for (int j = 0; j < 64; j++) payload[j] = 8'(8'hA0 ^ j);
        send_req(2'd0, 6'd20);
        fill(20, 1'b0);
        for (int k = 0; k < 11; k++) cyc();
        #1;
        check("before_reset_byte", 32'({bus.pkt_valid, bus.data_out}), 32'({1'b1, payload[10]}));
        resetn = 1'b0;
        #1;
        check("async_reset_out", 32'({bus.pkt_valid, bus.data_out}), 32'd0);
        check("async_reset_ready", 32'(bus.req_ready), 32'd1);
        cyc();
        resetn = 1'b1;
        #1;
        check("ready_after_release", 32'(bus.req_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (bus.done || bus.pkt_valid) seen++;
        end
        check("no_done_after_abort", 32'(seen), 32'd0);

        // normal packet after the abort
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        send_req(2'd1, 6'd3);
        fill(3, 1'b0);
        drain(3, 8'h0D, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
